// File: rtl/hqm_aw_sram_pg_access_ctl_if.sv
// Upstream request/response bundle of the power-gated SRAM access controller.
// The master issues requests and consumes read responses; the slave is the controller.
interface hqm_aw_sram_pg_access_ctl_if #(
  parameter int AW = 11,
  parameter int DW = 139
);
  logic          req_v;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_v;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_v, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_v, rsp_rdata
  );

  modport slave (
    input  req_v, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_v, rsp_rdata
  );
endinterface

// File: rtl/hqm_aw_sram_pg_access_ctl.sv
// Access controller for a power-gated single-port SRAM: turns a valid/ready stream into
// mem strobes, returns reads through a credit-protected buffer, and sequences power/isolation.
module hqm_aw_sram_pg_access_ctl #(
  parameter int AW         = 11,
  parameter int DW         = 139,
  parameter int RD_LAT     = 1,
  parameter int OBUF_DEPTH = 2,
  parameter int WAKE_CYC   = 8
) (
  input  logic                        clk,
  input  logic                        clk_rst,
  input  logic                        pwr_up_req,
  input  logic                        pwr_dn_req,
  output logic                        pwr_active,
  hqm_aw_sram_pg_access_ctl_if.slave  bus,
  output logic                        mem_re,
  output logic                        mem_we,
  output logic [AW-1:0]               mem_addr,
  output logic [DW-1:0]               mem_wdata,
  input  logic [DW-1:0]               mem_rdata,
  output logic                        mem_pwr_enable_b,
  input  logic                        mem_pwr_ack_b,
  output logic                        mem_isol_en
);

  localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int CW = $clog2(OBUF_DEPTH + 1);

  typedef enum logic [2:0] {
    ST_OFF, ST_WAKE, ST_SETTLE, ST_ACTIVE, ST_DRAIN, ST_ISO, ST_PDN
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [7:0]    cnt;
  logic [CW-1:0] inflight_cnt;
  logic [CW-1:0] obuf_cnt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [DW-1:0] obuf [OBUF_DEPTH];
  logic [RD_LAT-1:0] rd_pipe;
  logic [CW:0]   credit_sum;
  logic          credit_ok;
  logic          accept;
  logic          rd_accept;
  logic          push;
  logic          pop;

  // Reads accepted but not yet captured already own a buffer slot, so they count as credit.
  assign push       = rd_pipe[RD_LAT-1];
  assign pop        = bus.rsp_v & bus.rsp_ready;
  assign credit_sum = {1'b0, inflight_cnt} + {1'b0, obuf_cnt} - {{CW{1'b0}}, pop};
  assign credit_ok  = credit_sum < (CW+1)'(OBUF_DEPTH);

  assign bus.req_ready = (state == ST_ACTIVE) & ~pwr_dn_req & (bus.req_we | credit_ok);
  assign bus.rsp_v     = (obuf_cnt != '0);
  assign bus.rsp_rdata = obuf[rd_ptr];
  assign accept        = bus.req_v & bus.req_ready;
  assign rd_accept     = accept & ~bus.req_we;

  always_comb begin
    next_state = state;
    case (state)
      ST_OFF:    if (pwr_up_req && !pwr_dn_req) next_state = ST_WAKE;
      ST_WAKE:   if (pwr_dn_req) next_state = ST_PDN;
                 else if (!mem_pwr_ack_b) next_state = ST_SETTLE;
      ST_SETTLE: if (pwr_dn_req) next_state = ST_PDN;
                 else if (cnt == '0) next_state = ST_ACTIVE;
      ST_ACTIVE: if (pwr_dn_req) next_state = ST_DRAIN;
      ST_DRAIN:  if (inflight_cnt == '0 && obuf_cnt == '0) next_state = ST_ISO;
      ST_ISO:    next_state = ST_PDN;
      ST_PDN:    if (mem_pwr_ack_b) next_state = ST_OFF;
      default:   next_state = ST_OFF;
    endcase
  end

  // Power outputs are registered from the next state so they change on the state's entry edge.
  always_ff @(posedge clk) begin
    if (clk_rst) begin
      state            <= ST_OFF;
      cnt              <= '0;
      mem_pwr_enable_b <= 1'b1;
      mem_isol_en      <= 1'b1;
      pwr_active       <= 1'b0;
    end else begin
      state <= next_state;
      if (state == ST_WAKE && next_state == ST_SETTLE)
        cnt <= 8'(WAKE_CYC - 1);
      else if (state == ST_SETTLE && cnt != '0)
        cnt <= cnt - 8'd1;
      mem_pwr_enable_b <= (next_state == ST_OFF) || (next_state == ST_PDN);
      mem_isol_en      <= !((next_state == ST_ACTIVE) || (next_state == ST_DRAIN));
      pwr_active       <= (next_state == ST_ACTIVE);
    end
  end

  always_ff @(posedge clk) begin
    if (clk_rst) begin
      mem_re       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      rd_pipe      <= '0;
      inflight_cnt <= '0;
      obuf_cnt     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      mem_re <= rd_accept;
      mem_we <= accept & bus.req_we;
      if (accept)
        mem_addr <= bus.req_addr;
      if (accept && bus.req_we)
        mem_wdata <= bus.req_wdata;
      rd_pipe      <= RD_LAT'({rd_pipe, mem_re});
      inflight_cnt <= inflight_cnt + CW'(rd_accept) - CW'(push);
      obuf_cnt     <= obuf_cnt + CW'(push) - CW'(pop);
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      obuf[wr_ptr] <= mem_rdata;
  end

  obuf_no_overflow: assert property (@(posedge clk) disable iff (clk_rst)
    !(push && !pop && obuf_cnt == CW'(OBUF_DEPTH)));

endmodule
